// File: rtl/adc_trace_pkg.sv
// adc_trace_pkg: sample width, default capture geometry and the capture state type
// shared by the trace-capture block and its buffer RAM.
package adc_trace_pkg;

  localparam int unsigned SAMPLE_W         = 12;
  localparam int unsigned DEF_DEPTH        = 256;
  localparam int unsigned DEF_PRETRIG      = 32;
  localparam int unsigned DEF_AUTO_TIMEOUT = 4800;

  typedef enum logic [1:0] {
    ST_PRE,
    ST_ARM,
    ST_POST,
    ST_DONE
  } state_e;

endpackage

// File: rtl/adc_trace_ram.sv
// adc_trace_ram: DEPTH x SAMPLE_W simple dual-port buffer, one write port and one
// registered read port whose output register clears on reset (array contents do not).
module adc_trace_ram
  import adc_trace_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [SAMPLE_W-1:0] wdata_i,
  input  logic [AW-1:0]       raddr_i,
  output logic [SAMPLE_W-1:0] rdata_o
);

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [SAMPLE_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/adc_trace_capture.sv
// adc_trace_capture: triggered ADC trace capture into a circular buffer with frozen-frame
// readout. Define ADC_TRACE_AVG_EN to store the mean of every 4 ADC events instead of each one.
module adc_trace_capture
  import adc_trace_pkg::*;
#(
  parameter int unsigned DEPTH        = DEF_DEPTH,
  parameter int unsigned PRETRIG      = DEF_PRETRIG,
  parameter int unsigned AUTO_TIMEOUT = DEF_AUTO_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [SAMPLE_W-1:0]      adc_data,
  input  logic                     adc_sync,
  input  logic [SAMPLE_W-1:0]      trig_level,
  input  logic                     trig_slope,
  input  logic                     trig_mode,
  input  logic                     rearm,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [SAMPLE_W-1:0]      rd_data,
  output logic                     frame_ready,
  output logic                     triggered,
  output logic                     armed,
  output logic [SAMPLE_W-1:0]      sample_min,
  output logic [SAMPLE_W-1:0]      sample_max
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(((DEPTH > AUTO_TIMEOUT) ? DEPTH : AUTO_TIMEOUT) + 1);
  localparam logic [CW-1:0] PRE_LAST  = CW'(PRETRIG - 1);
  localparam logic [CW-1:0] POST_LAST = CW'(DEPTH - PRETRIG - 2);
  localparam logic [CW-1:0] TO_LAST   = CW'(AUTO_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                sync_q;
  logic                evt, pre_entry;
  logic                st_en;
  logic [SAMPLE_W-1:0] st_val;
  logic [AW-1:0]       wr_ptr_q, trig_ptr_q;
  logic [CW-1:0]       cnt_q, arm_cnt_q;
  logic [SAMPLE_W-1:0] prev_q, run_min_q, run_max_q, min_nxt, max_nxt;
  logic [SAMPLE_W-1:0] smin_q, smax_q;
  logic                trig_q, rise, fall, hit, timeout;

  // Loading adc_sync during reset too keeps the edge detector quiet after release.
  always_ff @(posedge clk) sync_q <= adc_sync;

  assign evt       = (adc_sync != sync_q) && (state_q != ST_DONE);
  assign pre_entry = (state_q == ST_DONE) && rearm;

`ifdef ADC_TRACE_AVG_EN
  logic [13:0] acc_q, acc_sum;
  logic [1:0]  acc_cnt_q;

  assign acc_sum = acc_q + 14'(adc_data);
  assign st_en   = evt && (acc_cnt_q == 2'd3);
  assign st_val  = acc_sum[13:2];

  always_ff @(posedge clk) begin
    if (!reset_n || pre_entry) begin
      acc_q     <= '0;
      acc_cnt_q <= '0;
    end else if (evt) begin
      acc_q     <= (acc_cnt_q == 2'd3) ? '0 : acc_sum;
      acc_cnt_q <= acc_cnt_q + 2'd1;
    end
  end
`else
  assign st_en  = evt;
  assign st_val = adc_data;
`endif

  assign rise    = (prev_q < trig_level) && (st_val >= trig_level);
  assign fall    = (prev_q > trig_level) && (st_val <= trig_level);
  assign hit     = trig_slope ? fall : rise;
  assign timeout = !trig_mode && (arm_cnt_q == TO_LAST);
  assign min_nxt = (st_en && (st_val < run_min_q)) ? st_val : run_min_q;
  assign max_nxt = (st_en && (st_val > run_max_q)) ? st_val : run_max_q;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_PRE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PRE:  if (st_en && (cnt_q == PRE_LAST))  state_d = ST_ARM;
      ST_ARM:  if (st_en && (hit || timeout))     state_d = ST_POST;
      ST_POST: if (st_en && (cnt_q == POST_LAST)) state_d = ST_DONE;
      ST_DONE: if (rearm)                         state_d = ST_PRE;
      default:                                    state_d = ST_PRE;
    endcase
  end

  always_comb begin
    armed       = (state_q == ST_ARM);
    frame_ready = (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      trig_ptr_q <= '0;
      cnt_q      <= '0;
      arm_cnt_q  <= '0;
      trig_q     <= 1'b0;
      prev_q     <= '0;
      run_min_q  <= '1;
      run_max_q  <= '0;
      smin_q     <= '0;
      smax_q     <= '0;
    end else begin
      if (st_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        prev_q   <= st_val;
      end
      if (state_d != state_q) cnt_q <= '0;
      else if (st_en)         cnt_q <= cnt_q + CW'(1);
      if (state_q == ST_PRE)
        arm_cnt_q <= '0;
      else if ((state_q == ST_ARM) && st_en && !trig_mode)
        arm_cnt_q <= arm_cnt_q + CW'(1);
      // A real crossing wins over a coincident timeout.
      if ((state_q == ST_ARM) && (state_d == ST_POST)) begin
        trig_ptr_q <= wr_ptr_q;
        trig_q     <= hit;
      end
      if (pre_entry) begin
        run_min_q <= '1;
        run_max_q <= '0;
      end else begin
        run_min_q <= min_nxt;
        run_max_q <= max_nxt;
      end
      if ((state_q == ST_POST) && (state_d == ST_DONE)) begin
        smin_q <= min_nxt;
        smax_q <= max_nxt;
      end
    end
  end

  assign triggered  = trig_q;
  assign sample_min = smin_q;
  assign sample_max = smax_q;

  adc_trace_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (st_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (st_val),
    .raddr_i (trig_ptr_q - AW'(PRETRIG) + rd_addr),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_adc_trace_capture.sv
// tb_adc_trace_capture: scenario tasks against an index-based model of the stored sample
// stream; works in both the default build and with ADC_TRACE_AVG_EN defined.
module tb_adc_trace_capture;

  localparam int DEPTH        = 256;
  localparam int PRETRIG      = 32;
  localparam int AUTO_TIMEOUT = 4800;
`ifdef ADC_TRACE_AVG_EN
  localparam int EV_PER = 4;
`else
  localparam int EV_PER = 1;
`endif

  logic        clk = 1'b0, reset_n = 1'b0, adc_sync = 1'b0;
  logic        trig_slope = 1'b0, trig_mode = 1'b1, rearm = 1'b0;
  logic [11:0] adc_data = '0, trig_level = 12'd2048;
  logic [7:0]  rd_addr = '0;
  logic [11:0] rd_data, sample_min, sample_max;
  logic        frame_ready, triggered, armed;

  int total = 0;
  int bad   = 0;
  logic [11:0] hist[$];

  adc_trace_capture #(
    .DEPTH        (DEPTH),
    .PRETRIG      (PRETRIG),
    .AUTO_TIMEOUT (AUTO_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .adc_data    (adc_data),
    .adc_sync    (adc_sync),
    .trig_level  (trig_level),
    .trig_slope  (trig_slope),
    .trig_mode   (trig_mode),
    .rearm       (rearm),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_ready (frame_ready),
    .triggered   (triggered),
    .armed       (armed),
    .sample_min  (sample_min),
    .sample_max  (sample_max)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic raw_event(input logic [11:0] v);
    adc_data = v;
    adc_sync = ~adc_sync;
    tick();
  endtask

  // One stored sample; in the averaging build it is spread over 4 events with mean v.
  task automatic send_stored(input logic [11:0] v);
`ifdef ADC_TRACE_AVG_EN
    if (v >= 12'd150 && v <= 12'd3945) begin
      raw_event(12'(v - 12'd150));
      raw_event(12'(v - 12'd50));
      raw_event(12'(v + 12'd50));
      raw_event(12'(v + 12'd150));
    end else begin
      repeat (4) raw_event(v);
    end
`else
    raw_event(v);
`endif
  endtask

  task automatic rd(input int a, output logic [11:0] d);
    rd_addr = 8'(a);
    tick();
    d = rd_data;
  endtask

  task automatic do_rearm();
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rearm   = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  function automatic logic [11:0] rnd12(input int lo, input int hi);
    return 12'($urandom_range(hi, lo));
  endfunction

  // Feeds hist from a fresh PRE state and checks the frame against the model.
  task automatic run_capture(input string nm, input bit mode, input bit slope,
                             input logic [11:0] lvl, input int post_rearm);
    int ti, di;
    bit rt;
    logic [11:0] mn, mx, d;
    int addrs[8];
    trig_mode  = mode;
    trig_slope = slope;
    trig_level = lvl;
    ti = -1;
    rt = 1'b0;
    for (int i = PRETRIG; i < hist.size(); i++) begin
      bit up, dn;
      up = (hist[i-1] < lvl) && (hist[i] >= lvl);
      dn = (hist[i-1] > lvl) && (hist[i] <= lvl);
      rt = slope ? dn : up;
      if (rt || (!mode && (i - PRETRIG + 1 == AUTO_TIMEOUT))) begin
        ti = i;
        break;
      end
    end
    di = ti + DEPTH - PRETRIG - 1;
    total++;
    if (ti < 0 || di >= hist.size()) begin
      bad++;
      $display("FAIL %s model: no complete frame in stimulus (trig idx %0d)", nm, ti);
      return;
    end
    mn = 12'hFFF;
    mx = 12'h000;
    for (int i = 0; i <= di; i++) begin
      if (hist[i] < mn) mn = hist[i];
      if (hist[i] > mx) mx = hist[i];
    end
    for (int i = 0; i <= di; i++) begin
      if (i == di) begin
        total++;
        if (frame_ready !== 1'b0) begin
          bad++;
          $display("FAIL %s early_ready: got %0b want 0", nm, frame_ready);
        end
      end
      if (post_rearm >= 0 && i == ti + 1 + post_rearm) do_rearm();
      send_stored(hist[i]);
      if (i == PRETRIG - 2) begin
        total++;
        if (armed !== 1'b0) begin
          bad++;
          $display("FAIL %s armed_in_pre: got %0b want 0", nm, armed);
        end
      end
      if (i == PRETRIG - 1) begin
        total++;
        if (armed !== 1'b1) begin
          bad++;
          $display("FAIL %s armed_after_pre: got %0b want 1", nm, armed);
        end
      end
    end
    total++;
    if (frame_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s frame_ready: got %0b want 1", nm, frame_ready);
    end
    total++;
    if (triggered !== rt) begin
      bad++;
      $display("FAIL %s triggered: got %0b want %0b", nm, triggered, rt);
    end
    total++;
    if (sample_min !== mn || sample_max !== mx) begin
      bad++;
      $display("FAIL %s minmax: got %0d/%0d want %0d/%0d", nm, sample_min, sample_max, mn, mx);
    end
    addrs = '{PRETRIG, PRETRIG - 1, 0, DEPTH - 1, 0, 0, 0, 0};
    for (int k = 4; k < 8; k++) addrs[k] = $urandom_range(DEPTH - 1, 0);
    foreach (addrs[k]) begin
      rd(addrs[k], d);
      total++;
      if (d !== hist[ti - PRETRIG + addrs[k]]) begin
        bad++;
        $display("FAIL %s read[%0d]: got %0d want %0d", nm, addrs[k], d,
                 hist[ti - PRETRIG + addrs[k]]);
      end
    end
    repeat (3) send_stored(rnd12(0, 4095));
    rd(PRETRIG, d);
    total++;
    if (d !== hist[ti] || frame_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s frozen: got %0d/%0b want %0d/1", nm, d, frame_ready, hist[ti]);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    adc_sync = ~adc_sync;
    tick();
    total++;
    if (frame_ready !== 1'b0 || triggered !== 1'b0 || armed !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: got %0b%0b%0b want 000", frame_ready, triggered, armed);
    end
    total++;
    if (rd_data !== 12'd0) begin
      bad++;
      $display("FAIL reset_rd_data: got %0d want 0", rd_data);
    end
    total++;
    if (sample_min !== 12'd0 || sample_max !== 12'd0) begin
      bad++;
      $display("FAIL reset_minmax: got %0d/%0d want 0/0", sample_min, sample_max);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_ramp();
    logic [11:0] d;
    hist.delete();
    repeat (3) for (int v = 0; v < 256; v++) hist.push_back(12'(v * 16));
    run_capture("ramp", 1'b1, 1'b0, 12'd2048, -1);
    rd(32, d);
    total++;
    if (d !== 12'd2048) begin
      bad++;
      $display("FAIL ramp_rd32: got %0d want 2048", d);
    end
    rd(31, d);
    total++;
    if (d !== 12'd2032) begin
      bad++;
      $display("FAIL ramp_rd31: got %0d want 2032", d);
    end
    do_rearm();
  endtask

  task automatic test_auto_timeout();
    hist.delete();
    repeat (5100) hist.push_back(12'd1000);
    run_capture("auto", 1'b0, 1'b0, 12'd2048, -1);
    total++;
    if (triggered !== 1'b0 || sample_min !== 12'd1000 || sample_max !== 12'd1000) begin
      bad++;
      $display("FAIL auto_const: got trig=%0b min=%0d max=%0d want 0/1000/1000",
               triggered, sample_min, sample_max);
    end
  endtask

  task automatic test_rearm();
    rearm = 1'b1;
    raw_event(12'd77);
    rearm = 1'b0;
    total++;
    if (armed !== 1'b0 || frame_ready !== 1'b0) begin
      bad++;
      $display("FAIL rearm_evt: got armed=%0b ready=%0b want 0/0", armed, frame_ready);
    end
    hist.delete();
    repeat (600) hist.push_back(rnd12(0, 4095));
    run_capture("rearm_post", 1'b1, 1'b0, 12'd2048, 40);
    do_rearm();
  endtask

  task automatic test_normal_hold();
    trig_mode  = 1'b1;
    trig_slope = 1'b0;
    trig_level = 12'd2048;
    repeat (10000 / EV_PER) send_stored(12'd1000);
    total++;
    if (frame_ready !== 1'b0 || armed !== 1'b1) begin
      bad++;
      $display("FAIL normal_hold: got ready=%0b armed=%0b want 0/1", frame_ready, armed);
    end
    do_reset();
  endtask

  task automatic test_pre_crossing();
    do_reset();
    hist.delete();
    for (int i = 0; i < PRETRIG; i++) hist.push_back((i % 2 == 0) ? 12'd100 : 12'd3000);
    repeat (229) hist.push_back(rnd12(0, 2047));
    hist.push_back(rnd12(2048, 4095));
    repeat (230) hist.push_back(rnd12(0, 4095));
    run_capture("pre_cross_wrap", 1'b1, 1'b0, 12'd2048, -1);
    do_rearm();
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) begin
      hist.delete();
      repeat (600) hist.push_back(rnd12(0, 4095));
      run_capture("random", 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                  rnd12(500, 3500), -1);
      do_rearm();
    end
  endtask

  task automatic test_reset_mid_post();
    trig_mode  = 1'b1;
    trig_slope = 1'b0;
    trig_level = 12'd2048;
    repeat (PRETRIG + 10) send_stored(12'd100);
    send_stored(12'd3000);
    repeat (50) send_stored(rnd12(0, 4095));
    reset_n = 1'b0;
    tick();
    total++;
    if (frame_ready !== 1'b0 || armed !== 1'b0) begin
      bad++;
      $display("FAIL mid_post_reset: got ready=%0b armed=%0b want 0/0", frame_ready, armed);
    end
    reset_n = 1'b1;
    hist.delete();
    repeat (600) hist.push_back(rnd12(0, 4095));
    run_capture("after_reset", 1'b1, 1'b1, 12'd2048, -1);
    do_rearm();
  endtask

  task automatic test_avg();
    logic [11:0] d;
    hist.delete();
    hist.push_back(12'd250);
    repeat (PRETRIG - 1) hist.push_back(rnd12(0, 1000));
    hist.push_back(12'd3000);
    repeat (240) hist.push_back(rnd12(0, 4095));
    run_capture("avg", 1'b1, 1'b0, 12'd2048, -1);
    rd(0, d);
    total++;
    if (d !== 12'd250) begin
      bad++;
      $display("FAIL avg_first: got %0d want 250", d);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_auto_timeout();
    test_rearm();
    test_normal_hold();
    test_pre_crossing();
    test_random();
    test_reset_mid_post();
    test_avg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
